bcd_to_binary_seq: RTL and testbench

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adjust.sv | 25 ++
 rtl/bcd_to_binary_seq.sv | 162 ++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential BCD-to-binary converter:
//   - default digit count and binary result width
//   - FSM state encoding
//   - largest legal BCD digit value and a digit-validity helper
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int NUM_DIGITS_DEF = 3;
  localparam int BIN_W_DEF      = 10;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // True when a nibble is a legal decimal digit (0..9).
  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// One digit of the reverse double-dabble correction: after the working
// register has been shifted right, a digit that reads 8 or more carried a
// "ten" down from the digit above and must be reduced by 3.
// Ports:
//   din  - 4-bit digit after the right shift
//   dout - corrected 4-bit digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Subtract 3 from digits at or above 8, pass others through.
  always_comb begin
    dout = din;
    if (din >= 4'd8) begin
      dout = din - 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential packed-BCD to binary converter using reverse double-dabble.
// The working register {digits, bin} is shifted right once per clock and every
// digit that ends up >= 8 is reduced by 3; after BIN_W iterations the binary
// value sits in bin. An input with any digit above 9 is rejected at once
// with err=1 and bin_out=0.
// Ports:
//   clk      - clock, rising edge active
//   reset_n  - asynchronous active-low reset
//   start    - conversion request, sampled only in IDLE
//   bcd_in   - packed BCD, most significant digit in the top nibble
//   busy     - high while a conversion is running
//   done     - one-cycle pulse when a result (or error) is available
//   bin_out  - binary result, held until the next completion
//   err      - last accepted input contained an illegal digit
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int BIN_W      = BIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int DW    = 4 * NUM_DIGITS;
  // Counter must reach BIN_W itself without wrapping.
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    digits;
  logic [DW-1:0]    digits_next;
  logic [BIN_W-1:0] bin;
  logic [BIN_W-1:0] bin_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             busy_next;
  logic             done_next;
  logic [BIN_W-1:0] bin_out_next;
  logic             err_next;

  logic [DW+BIN_W-1:0] work;
  logic [DW-1:0]       adj_digits;
  logic [BIN_W-1:0]    shifted_bin;
  logic                any_bad;

  // One iteration: shift the whole working register right by one bit.
  assign work        = {digits, bin} >> 1;
  assign shifted_bin = work[BIN_W-1:0];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (work[BIN_W + 4*i +: 4]),
      .dout (adj_digits[4*i +: 4])
    );
  end

  // Flag any nibble of the incoming word that is not a decimal digit.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      any_bad = any_bad | ~digit_ok(bcd_in[4*i +: 4]);
    end
  end

  // Next-state, datapath and next-output logic for the converter FSM.
  always_comb begin
    state_next   = state;
    digits_next  = digits;
    bin_next     = bin;
    cnt_next     = cnt;
    busy_next    = busy;
    done_next    = 1'b0;
    bin_out_next = bin_out;
    err_next     = err;

    case (state)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          if (any_bad) begin
            // Illegal digit: report immediately, never go busy.
            state_next   = ST_DONE;
            done_next    = 1'b1;
            err_next     = 1'b1;
            bin_out_next = {BIN_W{1'b0}};
          end else begin
            state_next  = ST_CONVERT;
            digits_next = bcd_in;
            bin_next    = {BIN_W{1'b0}};
            cnt_next    = {CNT_W{1'b0}};
            busy_next   = 1'b1;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_CONVERT: begin
        digits_next = adj_digits;
        bin_next    = shifted_bin;
        cnt_next    = cnt + CNT_ONE;
        if (cnt == LAST_ITER) begin
          // Final iteration: the shifted bin is the finished result.
          state_next   = ST_DONE;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          bin_out_next = shifted_bin;
          err_next     = 1'b0;
        end else begin
          busy_next = 1'b1;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here.
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, working register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      digits  <= {DW{1'b0}};
      bin     <= {BIN_W{1'b0}};
      cnt     <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= {BIN_W{1'b0}};
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      digits  <= digits_next;
      bin     <= bin_next;
      cnt     <= cnt_next;
      busy    <= busy_next;
      done    <= done_next;
      bin_out <= bin_out_next;
      err     <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench for bcd_to_binary_seq (NUM_DIGITS=3, BIN_W=10):
// a directed vector table, hand-written multi-cycle sequences and random
// BCD words checked against an arithmetic decimal-value model.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_binary_seq #(.NUM_DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
    int          exp_err;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decimal value of a packed BCD word and its legality.
  function automatic int model_value(input logic [11:0] v);
    int val;
    val = 0;
    for (int d = 2; d >= 0; d--) begin
      val = val * 10 + int'(v[4*d +: 4]);
    end
    return val;
  endfunction

  function automatic int model_bad(input logic [11:0] v);
    int bad;
    bad = 0;
    for (int d = 0; d < 3; d++) begin
      if (v[4*d +: 4] > 4'd9) bad = 1;
    end
    return bad;
  endfunction

  // Pulse start with v, scramble bcd_in after the accepting edge, and measure
  // edges-until-done and busy cycles. lat = -1 means done never came.
  task automatic run_conv(input logic [11:0] v, output int lat, output int busy_cnt,
                          output int got_bin, output int got_err);
    bcd_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    bcd_in = 12'($urandom);
    lat      = -1;
    busy_cnt = 0;
    got_bin  = -1;
    got_err  = -1;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat     = k;
        got_bin = int'(bin_out);
        got_err = int'(err);
        break;
      end
      step();
    end
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  int lat, bcnt, gbin, gerr;
  int ndone, last, pulses;
  logic [11:0] rv;

  initial begin
    vecs[0] = '{bcd: 12'h999, exp_bin: 999, exp_err: 0, exp_lat: 10, exp_busy: 10};
    vecs[1] = '{bcd: 12'h000, exp_bin: 0,   exp_err: 0, exp_lat: 10, exp_busy: 10};
    vecs[2] = '{bcd: 12'h255, exp_bin: 255, exp_err: 0, exp_lat: 10, exp_busy: 10};
    vecs[3] = '{bcd: 12'h512, exp_bin: 512, exp_err: 0, exp_lat: 10, exp_busy: 10};
    vecs[4] = '{bcd: 12'h9A5, exp_bin: 0,   exp_err: 1, exp_lat: 0,  exp_busy: 0};
    vecs[5] = '{bcd: 12'h042, exp_bin: 42,  exp_err: 0, exp_lat: 10, exp_busy: 10};
    vecs[6] = '{bcd: 12'h0F0, exp_bin: 0,   exp_err: 1, exp_lat: 0,  exp_busy: 0};
    vecs[7] = '{bcd: 12'h100, exp_bin: 100, exp_err: 0, exp_lat: 10, exp_busy: 10};

    reset_n = 1'b0;
    start   = 1'b0;
    bcd_in  = 12'h000;
    step();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_bin_out", {22'd0, bin_out}, 32'd0);
    reset_n = 1'b1;

    // Directed table, first conversion right after reset release.
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bcd, lat, bcnt, gbin, gerr);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_busy);
      chk($sformatf("vec%0d_bin_out", i), gbin, vecs[i].exp_bin);
      chk($sformatf("vec%0d_err", i), gerr, vecs[i].exp_err);
    end

    // Second start during CONVERT must be ignored.
    bcd_in = 12'h123;
    start  = 1'b1;
    step();
    start  = 1'b0;
    ndone  = 0;
    gbin   = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) begin
        bcd_in = 12'h999;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        ndone++;
        gbin = int'(bin_out);
      end
    end
    chk("ignore_start_done_count", ndone, 1);
    chk("ignore_start_bin_out", gbin, 123);

    // Reset in the middle of a conversion.
    bcd_in = 12'h999;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    chk("midconv_busy_before_reset", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bin_out", {22'd0, bin_out}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done || busy) ndone++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_conv(12'h042, lat, bcnt, gbin, gerr);
    chk("after_reset_latency", lat, 10);
    chk("after_reset_bin_out", gbin, 42);
    chk("after_reset_err", gerr, 0);

    // start held high: one result every 12 cycles.
    bcd_in = 12'h100;
    start  = 1'b1;
    last   = -1;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (done) begin
        chk("held_bin_out", {22'd0, bin_out}, 32'd100);
        if (last >= 0) chk("held_period", c - last, 12);
        last = c;
        pulses++;
      end
    end
    chk("held_pulse_count", pulses, 5);
    start = 1'b0;
    for (int c = 0; c < 14; c++) step();

    // Random stimulus against the arithmetic model, with hold checks.
    for (int r = 0; r < 40; r++) begin
      rv = 12'h000;
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(7, 0) == 0) rv[4*d +: 4] = 4'($urandom_range(15, 10));
        else rv[4*d +: 4] = 4'($urandom_range(9, 0));
      end
      run_conv(rv, lat, bcnt, gbin, gerr);
      if (model_bad(rv) != 0) begin
        chk("rand_err", gerr, 1);
        chk("rand_err_bin_out", gbin, 0);
        chk("rand_err_latency", lat, 0);
        chk("rand_err_busy", bcnt, 0);
      end else begin
        chk("rand_bin_out", gbin, model_value(rv));
        chk("rand_ok_err", gerr, 0);
        chk("rand_latency", lat, 10);
        chk("rand_busy", bcnt, 10);
      end
      bcd_in = 12'($urandom);
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) step();
      chk("rand_hold_bin_out", {22'd0, bin_out}, 32'(model_bad(rv) != 0 ? 0 : model_value(rv)));
      chk("rand_hold_err", {31'd0, err}, 32'(model_bad(rv)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
